instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the instruction RAM: owns the PC, drives FETCH_ADDRESS/stop, captures DATA,
//  and hands {PC, instruction} pairs to decode through a valid/ready output buffer.
//  Sits between the instruction RAM (combinational read, freezes DATA while stop=1) and the decode stage.
//  Accepts branch/jump redirects from execute; optionally detects the halt word.
// PARAMETERS
//  RESET_PC   32'h0000_0000  byte PC loaded on reset
//  RAM_WORDS  512            instruction RAM depth in words; PC wraps modulo RAM_WORDS*4
//  BUF_DEPTH  2              output buffer entries (power of two, >=2)
// PORTS
//  CLOCK           in   1   rising-edge clock
//  RESET           in   1   asynchronous, active-high reset
//  FETCH_ADDRESS   out  32  word index to instruction RAM = PC>>2 (zero-extended)
//  stop            out  1   1 = RAM must hold DATA (no fetch this cycle)
//  DATA            in   32  instruction word for FETCH_ADDRESS, valid same cycle
//  REDIRECT_VALID  in   1   execute requests PC change this cycle
//  REDIRECT_PC     in   32  new byte PC (bits[1:0] ignored, forced 0)
//  OUT_VALID       out  1   OUT_PC/OUT_INSTR hold a fetched instruction
//  OUT_READY       in   1   decode accepts; transfer when OUT_VALID & OUT_READY
//  OUT_PC          out  32  byte PC of OUT_INSTR
//  OUT_INSTR       out  32  instruction word
//  HALTED          out  1   halt word consumed by decode; sticky until RESET
// BEHAVIOUR
//  - Reset (async, any cycle): PC=RESET_PC, buffer empty, OUT_VALID=0, OUT_PC=0, OUT_INSTR=0,
//    HALTED=0, state=RUN, stop=1. First fetch in first cycle after RESET deasserts.
//  - fetch_en = state==RUN & ~REDIRECT_VALID & (buffer not full | pop this cycle); stop = ~fetch_en.
//  - On fetch_en: push {PC, DATA} into buffer; PC <= PC+4, wrap to 0 at RAM_WORDS*4. Zero bubble:
//    one instruction per cycle while decode keeps OUT_READY=1. Latency fetch->OUT_VALID: 1 cycle.
//  - Buffer: FIFO, BUF_DEPTH entries; push+pop same cycle legal when full; OUT_* = head entry,
//    stable while OUT_VALID & ~OUT_READY.
//  - Redirect (highest priority below reset): buffer flushed, no push, pop ignored,
//    PC <= {REDIRECT_PC[31:2],2'b00}, state HALT_PEND -> RUN; OUT_VALID=0 next cycle.
//    Redirect while HALTED: ignored.
//  - States: RUN (fetching) / HALT_PEND (halt word in buffer, fetch stopped) / HALTED (terminal).
//    Transitions given under CONFIGURATION.
//  - Unaligned PC impossible (bits[1:0] always 0). No output is X after reset.
// CONFIGURATION
//  Macro FETCH_HALT_DETECT_EN:
//  - defined: DATA==32'hFFFF_FFFF on fetch -> pushed, RUN->HALT_PEND (stop held 1).
//    Halt word popped by decode -> HALTED=1, state HALTED, stop=1, OUT_VALID=0 forever.
//    Redirect in HALT_PEND flushes it and returns to RUN (halt was speculative).
//  - undefined: all-ones is an ordinary word; state stays RUN; HALTED tied 0.
// STRUCTURE
//  - Shared package cpu_pkg: HALT_WORD=32'hFFFF_FFFF, fetch state enum (FS_RUN/FS_HALT_PEND/FS_HALTED),
//    fetch_entry_t struct {pc[31:0], instr[31:0]}.
//  - One sub-module: fetch_buffer (sync FIFO of fetch_entry_t, push/pop/flush, full/empty, async reset).
//  - Top: PC register, fetch_en logic, state machine, RAM interface.
// TESTING
//  - Straight-line: RAM[0..3]=I0..I3, OUT_READY=1 -> OUT_PC 0,4,8,12 on consecutive cycles, FETCH_ADDRESS 0,1,2,3.
//  - Backpressure: OUT_READY=0 for 5 cycles -> exactly BUF_DEPTH=2 entries held, stop=1, OUT_PC=0 stable;
//    release -> PC 0,4,8 in order, none lost/duplicated.
//  - Redirect: REDIRECT_VALID=1, REDIRECT_PC=0x47 with 2 entries buffered -> next cycle OUT_VALID=0,
//    then OUT_PC=0x44, FETCH_ADDRESS=0x11.
//  - Halt (macro on): RAM[3]=FFFF_FFFF -> fetch stops after PC 12, HALTED=1 cycle after PC 12 popped;
//    redirect afterwards ignored. Macro off: fetch continues to PC 16, HALTED=0.
//  - Reset mid-stream: assert RESET with full buffer between edges -> OUT_VALID=0, stop=1 immediately;
//    after release first OUT_PC=RESET_PC.
//  - Wrap: REDIRECT_PC=0x7FC (RAM_WORDS=512) -> OUT_PC 0x7FC then 0x000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: halt word, fetch state encoding, fetch buffer entry.
// Imported by the fetch unit and its buffer.
package cpu_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        FS_RUN,
        FS_HALT_PEND,
        FS_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Sync FIFO of fetch_entry_t between fetch and decode.
// Ports: clk, rst (async high), push/pop/flush, din, head, full, empty.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  mem [DEPTH];

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full buffer is legal only alongside a pop.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count
                   + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns PC, drives instruction RAM, buffers {PC,instr} to decode.
// Ports: CLOCK, RESET (async high); RAM: FETCH_ADDRESS, stop, DATA;
// execute: REDIRECT_VALID/REDIRECT_PC; decode: OUT_VALID/OUT_READY/OUT_PC/
// OUT_INSTR; HALTED. Macro FETCH_HALT_DETECT_EN enables halt-word detection.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAM_WORDS = 512,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    output logic [31:0] FETCH_ADDRESS,
    output logic        stop,
    input  logic [31:0] DATA,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_PC,
    output logic [31:0] OUT_INSTR,
    output logic        HALTED
);

    localparam logic [31:0] PC_LIMIT = 32'(RAM_WORDS * 4);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [31:0]  pc_inc;
    logic         redirect;
    logic         pop;
    logic         fetch_en;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t head;
    fetch_entry_t entry;

    // Once halted the unit is terminal; redirects no longer apply.
    assign redirect  = REDIRECT_VALID & (state != FS_HALTED);
    assign OUT_VALID = ~buf_empty & (state != FS_HALTED);
    assign pop       = OUT_VALID & OUT_READY & ~redirect;
    assign fetch_en  = ~RESET & (state == FS_RUN) & ~redirect
                     & (~buf_full | pop);
    assign stop      = ~fetch_en;

    assign FETCH_ADDRESS = {2'b00, pc[31:2]};
    assign OUT_PC        = OUT_VALID ? head.pc : 32'd0;
    assign OUT_INSTR     = OUT_VALID ? head.instr : 32'd0;
    assign entry         = '{pc: pc, instr: DATA};
    assign pc_inc        = pc + 32'd4;

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = {REDIRECT_PC[31:2], 2'b00};
        end else if (fetch_en) begin
            pc_next = (pc_inc == PC_LIMIT) ? 32'd0 : pc_inc;
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_comb begin
        state_next = state;
        unique case (state)
            FS_RUN: begin
                if (fetch_en && DATA == HALT_WORD)
                    state_next = FS_HALT_PEND;
            end
            FS_HALT_PEND: begin
                // Halt is speculative until decode consumes it.
                if (redirect)
                    state_next = FS_RUN;
                else if (pop && head.instr == HALT_WORD)
                    state_next = FS_HALTED;
            end
            FS_HALTED: state_next = FS_HALTED;
            default:   state_next = FS_RUN;
        endcase
    end

    assign HALTED = (state == FS_HALTED);
`else
    always_comb begin
        state_next = FS_RUN;
    end

    assign HALTED = 1'b0;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= FS_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (CLOCK),
        .rst   (RESET),
        .push  (fetch_en),
        .pop   (pop),
        .flush (redirect),
        .din   (entry),
        .head  (head),
        .full  (buf_full),
        .empty (buf_empty)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit.
// Directed scenarios plus a randomized stream against a queue-level model.
module tb_instruction_fetch_unit;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] FETCH_ADDRESS;
    logic        stop;
    logic [31:0] DATA;
    logic        REDIRECT_VALID = 1'b0;
    logic [31:0] REDIRECT_PC = 32'd0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] OUT_PC;
    logic [31:0] OUT_INSTR;
    logic        HALTED;

    logic [31:0] ram [512];
    int errors = 0;
    int checks = 0;

    assign DATA = ram[FETCH_ADDRESS[8:0]];

    always #5 CLOCK = ~CLOCK;

    instruction_fetch_unit dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .FETCH_ADDRESS  (FETCH_ADDRESS),
        .stop           (stop),
        .DATA           (DATA),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .OUT_PC         (OUT_PC),
        .OUT_INSTR      (OUT_INSTR),
        .HALTED         (HALTED)
    );

    function automatic logic [31:0] nxt(input logic [31:0] p);
        return (p + 32'd4 == 32'h800) ? 32'd0 : p + 32'd4;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0000_0013;
        return w;
    endfunction

    // Leaves RESET released at posedge+1 of the first fetch cycle.
    task automatic do_reset(input logic rdy);
        RESET = 1'b1;
        REDIRECT_VALID = 1'b0;
        OUT_READY = rdy;
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || stop !== 1'b1 || OUT_PC !== 32'd0
            || OUT_INSTR !== 32'd0 || HALTED !== 1'b0
            || FETCH_ADDRESS !== 32'd0) begin
            errors++;
            $display("FAIL reset: v=%b stop=%b pc=%h ins=%h h=%b fa=%h",
                OUT_VALID, stop, OUT_PC, OUT_INSTR, HALTED, FETCH_ADDRESS);
        end
        do_reset(1'b0);
        #1;
        checks++;
        if (stop !== 1'b0 || FETCH_ADDRESS !== 32'd0) begin
            errors++;
            $display("FAIL reset_first_fetch: stop=%b fa=%h want 0/0",
                stop, FETCH_ADDRESS);
        end
    endtask

    task automatic test_straight();
        do_reset(1'b1);
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || FETCH_ADDRESS !== 32'd0) begin
            errors++;
            $display("FAIL straight_start: v=%b fa=%h", OUT_VALID,
                FETCH_ADDRESS);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge CLOCK); #2;
            checks++;
            if (OUT_VALID !== 1'b1 || OUT_PC !== 32'(4*k)
                || OUT_INSTR !== ram[k] || FETCH_ADDRESS !== 32'(k+1)
                || stop !== 1'b0) begin
                errors++;
                $display("FAIL straight_%0d: v=%b pc=%h ins=%h fa=%h st=%b want pc=%h ins=%h fa=%h",
                    k, OUT_VALID, OUT_PC, OUT_INSTR, FETCH_ADDRESS, stop,
                    32'(4*k), ram[k], 32'(k+1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        int n;
        do_reset(1'b0);
        repeat (2) @(posedge CLOCK);
        #2;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (stop !== 1'b1 || OUT_VALID !== 1'b1 || OUT_PC !== 32'd0
                || OUT_INSTR !== ram[0]) begin
                errors++;
                $display("FAIL bp_hold_%0d: st=%b v=%b pc=%h ins=%h want 1/1/0",
                    k, stop, OUT_VALID, OUT_PC, OUT_INSTR);
            end
            @(posedge CLOCK); #2;
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (stop !== 1'b0 || FETCH_ADDRESS !== 32'd2) begin
            errors++;
            $display("FAIL bp_release: st=%b fa=%h want 0/2", stop,
                FETCH_ADDRESS);
        end
        exp = 32'd0;
        n = 0;
        for (int c = 0; c < 10 && n < 3; c++) begin
            if (OUT_VALID && OUT_READY) begin
                checks++;
                if (OUT_PC !== exp || OUT_INSTR !== ram[exp[10:2]]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: pc=%h ins=%h want %h/%h",
                        n, OUT_PC, OUT_INSTR, exp, ram[exp[10:2]]);
                end
                exp = nxt(exp);
                n++;
            end
            @(posedge CLOCK); #2;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers want 3", n);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (2) @(posedge CLOCK);
        #1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = 32'h47;
        #1;
        checks++;
        if (stop !== 1'b1) begin
            errors++;
            $display("FAIL redir_stop: st=%b want 1", stop);
        end
        @(posedge CLOCK); #1;
        REDIRECT_VALID = 1'b0;
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || FETCH_ADDRESS !== 32'h11
            || stop !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: v=%b fa=%h st=%b want 0/11/0",
                OUT_VALID, FETCH_ADDRESS, stop);
        end
        @(posedge CLOCK); #2;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_PC !== 32'h44
            || OUT_INSTR !== ram[17]) begin
            errors++;
            $display("FAIL redir_target: v=%b pc=%h ins=%h want 1/44/%h",
                OUT_VALID, OUT_PC, OUT_INSTR, ram[17]);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = 32'h7FC;
        @(posedge CLOCK); #1;
        REDIRECT_VALID = 1'b0;
        #1;
        checks++;
        if (FETCH_ADDRESS !== 32'h1FF) begin
            errors++;
            $display("FAIL wrap_fa: fa=%h want 1ff", FETCH_ADDRESS);
        end
        @(posedge CLOCK); #2;
        checks++;
        if (OUT_PC !== 32'h7FC || OUT_INSTR !== ram[511]
            || FETCH_ADDRESS !== 32'd0) begin
            errors++;
            $display("FAIL wrap_last: pc=%h ins=%h fa=%h want 7fc/%h/0",
                OUT_PC, OUT_INSTR, FETCH_ADDRESS, ram[511]);
        end
        @(posedge CLOCK); #2;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd0
            || OUT_INSTR !== ram[0]) begin
            errors++;
            $display("FAIL wrap_zero: v=%b pc=%h ins=%h want 1/0/%h",
                OUT_VALID, OUT_PC, OUT_INSTR, ram[0]);
        end
    endtask

    task automatic test_halt();
        ram[3] = 32'hFFFF_FFFF;
        do_reset(1'b1);
        repeat (4) @(posedge CLOCK);
        #2;
`ifdef FETCH_HALT_DETECT_EN
        checks++;
        if (stop !== 1'b1 || OUT_PC !== 32'd12 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL halt_pend: st=%b pc=%h h=%b want 1/c/0",
                stop, OUT_PC, HALTED);
        end
        @(posedge CLOCK); #1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = 32'h20;
        #1;
        checks++;
        if (HALTED !== 1'b1 || OUT_VALID !== 1'b0 || stop !== 1'b1) begin
            errors++;
            $display("FAIL halted: h=%b v=%b st=%b want 1/0/1",
                HALTED, OUT_VALID, stop);
        end
        @(posedge CLOCK); #1;
        REDIRECT_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (HALTED !== 1'b1 || OUT_VALID !== 1'b0 || stop !== 1'b1) begin
                errors++;
                $display("FAIL halt_sticky_%0d: h=%b v=%b st=%b",
                    k, HALTED, OUT_VALID, stop);
            end
            @(posedge CLOCK); #1;
        end
        do_reset(1'b1);
        repeat (4) @(posedge CLOCK);
        #1;
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC = 32'h40;
        @(posedge CLOCK); #1;
        REDIRECT_VALID = 1'b0;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || FETCH_ADDRESS !== 32'h10
            || stop !== 1'b0 || HALTED !== 1'b0) begin
            errors++;
            $display("FAIL halt_spec_redir: v=%b fa=%h st=%b h=%b",
                OUT_VALID, FETCH_ADDRESS, stop, HALTED);
        end
`else
        checks++;
        if (stop !== 1'b0 || OUT_PC !== 32'd12 || FETCH_ADDRESS !== 32'd4
            || OUT_INSTR !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL nohalt_word: st=%b pc=%h fa=%h ins=%h",
                stop, OUT_PC, FETCH_ADDRESS, OUT_INSTR);
        end
        @(posedge CLOCK); #2;
        checks++;
        if (OUT_PC !== 32'd16 || HALTED !== 1'b0 || OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL nohalt_cont: pc=%h h=%b v=%b want 10/0/1",
                OUT_PC, HALTED, OUT_VALID);
        end
`endif
        ram[3] = rand_word();
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b0);
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        #1;
        checks++;
        if (OUT_VALID !== 1'b0 || stop !== 1'b1 || OUT_PC !== 32'd0) begin
            errors++;
            $display("FAIL midreset: v=%b st=%b pc=%h want 0/1/0",
                OUT_VALID, stop, OUT_PC);
        end
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        OUT_READY = 1'b1;
        @(posedge CLOCK); #2;
        checks++;
        if (OUT_VALID !== 1'b1 || OUT_PC !== 32'd0
            || OUT_INSTR !== ram[0]) begin
            errors++;
            $display("FAIL midreset_restart: v=%b pc=%h ins=%h want 1/0/%h",
                OUT_VALID, OUT_PC, OUT_INSTR, ram[0]);
        end
    endtask

    // Model: fetched-but-undelivered count, next fetch PC, next delivered PC.
    task automatic test_random_stream();
        logic [31:0] fpc;
        logic [31:0] opc;
        logic [31:0] tgt;
        logic        rdy;
        logic        rd;
        logic        xfer;
        logic        exp_stop;
        int          occ;
        fpc = 32'd0;
        opc = 32'd0;
        occ = 0;
        do_reset(1'b0);
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            tgt = 32'($urandom_range(0, 32'h7FF));
            OUT_READY = rdy;
            REDIRECT_VALID = rd;
            REDIRECT_PC = tgt;
            #1;
            xfer = (occ != 0) && rdy && !rd;
            exp_stop = rd || (occ == 2 && !xfer);
            checks++;
            if (OUT_VALID !== (occ != 0) || stop !== exp_stop) begin
                errors++;
                $display("FAIL rnd_ctl_%0d: v=%b st=%b want %b/%b",
                    c, OUT_VALID, stop, occ != 0, exp_stop);
            end
            if (xfer) begin
                checks++;
                if (OUT_PC !== opc || OUT_INSTR !== ram[opc[10:2]]) begin
                    errors++;
                    $display("FAIL rnd_out_%0d: pc=%h ins=%h want %h/%h",
                        c, OUT_PC, OUT_INSTR, opc, ram[opc[10:2]]);
                end
                opc = nxt(opc);
                occ--;
            end
            if (!exp_stop) begin
                checks++;
                if (FETCH_ADDRESS !== {2'b00, fpc[31:2]}) begin
                    errors++;
                    $display("FAIL rnd_fa_%0d: fa=%h want %h",
                        c, FETCH_ADDRESS, {2'b00, fpc[31:2]});
                end
                fpc = nxt(fpc);
                occ++;
            end
            if (rd) begin
                occ = 0;
                fpc = {tgt[31:2], 2'b00};
                opc = fpc;
            end
            @(posedge CLOCK); #1;
        end
        REDIRECT_VALID = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = rand_word();
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_midstream();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
